// File: rtl/board_io_pkg.sv
// Shared types and widths for the board bring-up tester.
`timescale 1ns/1ps
package board_io_pkg;

    localparam int IO_MODE_W   = 2;
    localparam int PRESS_CNT_W = 8;

    typedef enum logic [IO_MODE_W-1:0] {
        IO_ALT      = 2'd0,
        IO_WALK     = 2'd1,
        IO_ALL_HIGH = 2'd2
    } io_mode_t;

endpackage

// File: rtl/key_debounce.sv
// One active-low key: 2-FF synchroniser, stable-count debounce and press pulse.
`timescale 1ns/1ps
module key_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic down,
    output logic press
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             db_level;
    logic [CNT_W-1:0] db_cnt;
    logic             differs;
    logic             accept;

    assign differs = (sync_p1 != db_level);
    assign accept  = differs && (db_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0  <= 1'b1;
            sync_p1  <= 1'b1;
            db_level <= 1'b1;
            db_cnt   <= '0;
            press    <= 1'b0;
        end else begin
            sync_p0 <= key_raw;
            sync_p1 <= sync_p0;
            // pulse only on the accepted transition to the pressed (low) level
            press   <= accept && !sync_p1;
            if (!differs) begin
                db_cnt <= '0;
            end else if (accept) begin
                db_level <= sync_p1;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

    assign down = ~db_level;

endmodule

// File: rtl/board_io_tester.sv
// Board bring-up: key debounce, LED blink status and IO bank test patterns.
// Optional per-key press counters are built when BOARD_IO_PRESS_CNT_EN is defined.
`timescale 1ns/1ps
module board_io_tester
    import board_io_pkg::*;
#(
    parameter int N_KEYS        = 4,
    parameter int N_IO          = 34,
    parameter int DIV_W         = 25,
    parameter int FAST_BIT      = 20,
    parameter int STEP_BIT      = 22,
    parameter int DB_CYCLES     = 1000000,
    parameter int N_STATUS_LEDS = 2,
    parameter int MODE_KEY      = 3
) (
    input  logic                          i_sys_clk,
    input  logic                          i_rst,
    input  logic [N_KEYS-1:0]             i_key,
    input  logic                          i_status_ok,
    output logic [N_KEYS-1:0]             o_led,
    output logic [N_IO-1:0]               o_io,
    output logic [N_KEYS-1:0]             o_key_down,
    output logic [N_KEYS-1:0]             o_key_press,
    output logic [IO_MODE_W-1:0]          o_io_mode,
    output logic [PRESS_CNT_W*N_KEYS-1:0] o_press_cnt
);

    localparam int POS_W = $clog2(N_IO);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_IO - 1);

    logic [DIV_W-1:0]  cnt;
    logic [N_KEYS-1:0] key_down;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] led_next;
    logic [N_IO-1:0]   io_next;
    logic [POS_W-1:0]  pos;
    io_mode_t          mode;
    logic              step_tick;
    logic              mode_press;

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        key_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_key_debounce (
            .clk    (i_sys_clk),
            .rst    (i_rst),
            .key_raw(i_key[k]),
            .down   (key_down[k]),
            .press  (key_press[k])
        );
    end

    assign o_key_down  = key_down;
    assign o_key_press = key_press;
    assign mode_press  = key_press[MODE_KEY];
    assign step_tick   = &cnt[STEP_BIT:0];

    always_comb begin
        led_next = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            if (key_down[k]) begin
                led_next[k] = cnt[FAST_BIT];
            end else if (k < N_STATUS_LEDS) begin
                led_next[k] = i_status_ok ? cnt[DIV_W-1] : cnt[DIV_W-2];
            end else begin
                led_next[k] = cnt[DIV_W-1];
            end
        end
    end

    // A mode-change press takes priority over a walk step on the same cycle.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            mode <= IO_ALT;
            pos  <= '0;
        end else begin
            case (mode)
                IO_ALT: begin
                    if (mode_press) begin
                        mode <= IO_WALK;
                        pos  <= '0;
                    end
                end
                IO_WALK: begin
                    if (mode_press) begin
                        mode <= IO_ALL_HIGH;
                        pos  <= '0;
                    end else if (step_tick) begin
                        pos <= (pos == POS_LAST) ? '0 : pos + POS_W'(1);
                    end
                end
                IO_ALL_HIGH: begin
                    if (mode_press) begin
                        mode <= IO_ALT;
                        pos  <= '0;
                    end
                end
                default: begin
                    mode <= IO_ALT;
                    pos  <= '0;
                end
            endcase
        end
    end

    assign o_io_mode = mode;

    always_comb begin
        io_next = '0;
        case (mode)
            IO_ALT: begin
                for (int i = 0; i < N_IO; i++) begin
                    io_next[i] = cnt[DIV_W-1] ^ i[0];
                end
            end
            IO_WALK:     io_next[pos] = 1'b1;
            IO_ALL_HIGH: io_next = '1;
            default:     io_next = '0;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            o_led <= '0;
            o_io  <= '0;
        end else begin
            o_led <= led_next;
            o_io  <= io_next;
        end
    end

`ifdef BOARD_IO_PRESS_CNT_EN
    function automatic logic [PRESS_CNT_W-1:0] sat_inc(input logic [PRESS_CNT_W-1:0] val);
        return (&val) ? val : val + PRESS_CNT_W'(1);
    endfunction

    for (genvar k = 0; k < N_KEYS; k++) begin : g_press_cnt
        logic [PRESS_CNT_W-1:0] press_cnt;

        always_ff @(posedge i_sys_clk) begin
            if (i_rst) begin
                press_cnt <= '0;
            end else if (key_press[k]) begin
                press_cnt <= sat_inc(press_cnt);
            end
        end

        assign o_press_cnt[PRESS_CNT_W*k +: PRESS_CNT_W] = press_cnt;
    end
`else
    assign o_press_cnt = '0;
`endif

endmodule

// File: tb/tb_board_io_tester.sv
// Scoreboard bench for board_io_tester with small divider/debounce parameters.
`timescale 1ns/1ps
module tb_board_io_tester;

    localparam int N_KEYS        = 4;
    localparam int N_IO          = 6;
    localparam int DIV_W         = 8;
    localparam int FAST_BIT      = 2;
    localparam int STEP_BIT      = 3;
    localparam int DB_CYCLES     = 4;
    localparam int N_STATUS_LEDS = 2;
    localparam int MODE_KEY      = 3;

    localparam int SEL_LED   = 0;
    localparam int SEL_IO    = 1;
    localparam int SEL_DOWN  = 2;
    localparam int SEL_PRESS = 3;
    localparam int SEL_MODE  = 4;
    localparam int SEL_PCNT  = 5;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N_KEYS-1:0]   key = '1;
    logic                status_ok = 1'b0;
    logic [N_KEYS-1:0]   led;
    logic [N_IO-1:0]     io;
    logic [N_KEYS-1:0]   key_down;
    logic [N_KEYS-1:0]   key_press;
    logic [1:0]          io_mode;
    logic [8*N_KEYS-1:0] press_cnt;

    board_io_tester #(
        .N_KEYS       (N_KEYS),
        .N_IO         (N_IO),
        .DIV_W        (DIV_W),
        .FAST_BIT     (FAST_BIT),
        .STEP_BIT     (STEP_BIT),
        .DB_CYCLES    (DB_CYCLES),
        .N_STATUS_LEDS(N_STATUS_LEDS),
        .MODE_KEY     (MODE_KEY)
    ) dut (
        .i_sys_clk  (clk),
        .i_rst      (rst),
        .i_key      (key),
        .i_status_ok(status_ok),
        .o_led      (led),
        .o_io       (io),
        .o_key_down (key_down),
        .o_key_press(key_press),
        .o_io_mode  (io_mode),
        .o_press_cnt(press_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    string       sb_tag[$];
    int          sb_due[$];
    int          sb_sel[$];
    logic [63:0] sb_mask[$];
    logic [63:0] sb_exp[$];

    // Bench-side view of the design state, advanced from the stimulus script.
    logic [DIV_W-1:0]  m_cnt = '0;
    int                m_mode = 0;
    int                m_pos = 0;
    logic [N_KEYS-1:0] m_down = '0;
    logic              m_adv = 1'b0;
    int                m_pinc = -1;
    int                m_pcnt[N_KEYS];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            SEL_LED:   return 64'(led);
            SEL_IO:    return 64'(io);
            SEL_DOWN:  return 64'(key_down);
            SEL_PRESS: return 64'(key_press);
            SEL_MODE:  return 64'(io_mode);
            default:   return 64'(press_cnt);
        endcase
    endfunction

    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb_due.size()) begin
            if (sb_due[i] <= cyc) begin
                check_val(sb_tag[i], observe(sb_sel[i]) & sb_mask[i], sb_exp[i] & sb_mask[i]);
                sb_tag.delete(i);
                sb_due.delete(i);
                sb_sel.delete(i);
                sb_mask.delete(i);
                sb_exp.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic push(input string tag, input int sel, input int due,
                        input logic [63:0] mask, input logic [63:0] exp);
        sb_tag.push_back(tag);
        sb_sel.push_back(sel);
        sb_due.push_back(due);
        sb_mask.push_back(mask);
        sb_exp.push_back(exp);
    endtask

    function automatic logic [63:0] exp_led(input logic [DIV_W-1:0] c, input logic st,
                                            input logic [N_KEYS-1:0] dn);
        logic [N_KEYS-1:0] r;
        for (int k = 0; k < N_KEYS; k++) begin
            if (dn[k])                  r[k] = c[FAST_BIT];
            else if (k < N_STATUS_LEDS) r[k] = st ? c[DIV_W-1] : c[DIV_W-2];
            else                        r[k] = c[DIV_W-1];
        end
        return 64'(r);
    endfunction

    function automatic logic [63:0] exp_io(input int md, input int p, input logic [DIV_W-1:0] c);
        logic [N_IO-1:0] r;
        r = '0;
        case (md)
            0: for (int i = 0; i < N_IO; i++) r[i] = (i % 2 == 0) ? c[DIV_W-1] : ~c[DIV_W-1];
            1: r[p] = 1'b1;
            2: r = '1;
            default: r = '0;
        endcase
        return 64'(r);
    endfunction

    function automatic logic [63:0] exp_pcnt();
        logic [8*N_KEYS-1:0] r;
        r = '0;
`ifdef BOARD_IO_PRESS_CNT_EN
        for (int k = 0; k < N_KEYS; k++) r[8*k +: 8] = 8'(m_pcnt[k]);
`endif
        return 64'(r);
    endfunction

    task automatic cycle();
        if (!rst) begin
            push("led", SEL_LED, cyc + 1, 64'hF, exp_led(m_cnt, status_ok, m_down));
            push("io", SEL_IO, cyc + 1, 64'h3F, exp_io(m_mode, m_pos, m_cnt));
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_cnt  = '0;
            m_mode = 0;
            m_pos  = 0;
            m_down = '0;
            m_adv  = 1'b0;
            m_pinc = -1;
            for (int k = 0; k < N_KEYS; k++) m_pcnt[k] = 0;
        end else begin
            if (m_adv) begin
                m_mode = (m_mode + 1) % 3;
                m_pos  = 0;
                m_adv  = 1'b0;
            end else if (m_mode == 1 && m_cnt[STEP_BIT:0] == '1) begin
                m_pos = (m_pos + 1) % N_IO;
            end
            if (m_pinc >= 0) begin
                if (m_pcnt[m_pinc] < 255) m_pcnt[m_pinc]++;
                m_pinc = -1;
            end
            m_cnt = m_cnt + 1'b1;
            push("mode", SEL_MODE, cyc, 64'h3, 64'(m_mode));
            push("pcnt", SEL_PCNT, cyc, 64'hFFFF_FFFF, exp_pcnt());
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic hold_quiet(input int n);
        repeat (n) begin
            push("down_hold", SEL_DOWN, cyc + 1, 64'hF, 64'(m_down));
            push("press_hold", SEL_PRESS, cyc + 1, 64'hF, 64'h0);
            cycle();
        end
    endtask

    task automatic press_key(input int k);
        logic [N_KEYS-1:0] b;
        b = '0;
        b[k] = 1'b1;
        key[k] = 1'b0;
        hold_quiet(DB_CYCLES + 1);
        push("down_rise", SEL_DOWN, cyc + 1, 64'hF, 64'(m_down | b));
        push("press_pulse", SEL_PRESS, cyc + 1, 64'hF, 64'(b));
        cycle();
        m_down = m_down | b;
        if (k == MODE_KEY) m_adv = 1'b1;
        m_pinc = k;
        push("press_end", SEL_PRESS, cyc + 1, 64'hF, 64'h0);
        cycle();
    endtask

    task automatic release_key(input int k);
        logic [N_KEYS-1:0] b;
        b = '0;
        b[k] = 1'b1;
        key[k] = 1'b1;
        hold_quiet(DB_CYCLES + 1);
        push("down_fall", SEL_DOWN, cyc + 1, 64'hF, 64'(m_down & ~b));
        push("release_nopulse", SEL_PRESS, cyc + 1, 64'hF, 64'h0);
        cycle();
        m_down = m_down & ~b;
        hold_quiet(1);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        key = '1;
        repeat (n) cycle();
        push("rst_led", SEL_LED, cyc, 64'hF, 64'h0);
        push("rst_io", SEL_IO, cyc, 64'h3F, 64'h0);
        push("rst_down", SEL_DOWN, cyc, 64'hF, 64'h0);
        push("rst_press", SEL_PRESS, cyc, 64'hF, 64'h0);
        push("rst_mode", SEL_MODE, cyc, 64'h3, 64'h0);
        push("rst_pcnt", SEL_PCNT, cyc, 64'hFFFF_FFFF, 64'h0);
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] sat_exp;
        for (int k = 0; k < N_KEYS; k++) m_pcnt[k] = 0;

        do_reset(3);
        idle(256);

        // glitch shorter than the debounce window
        key[0] = 1'b0;
        hold_quiet(3);
        key[0] = 1'b1;
        hold_quiet(8);

        // accepted press, fast blink while held
        press_key(2);
        idle(20);
        release_key(2);

        status_ok = 1'b0;
        idle(130);
        status_ok = 1'b1;
        idle(130);
        status_ok = 1'b0;

        // ALT -> WALK (long enough to see the walk wrap) -> ALL_HIGH -> ALT
        press_key(MODE_KEY);
        idle(110);
        release_key(MODE_KEY);
        press_key(MODE_KEY);
        idle(20);
        release_key(MODE_KEY);
        press_key(MODE_KEY);
        idle(20);
        release_key(MODE_KEY);

        repeat (300) begin
            press_key(1);
            release_key(1);
        end
`ifdef BOARD_IO_PRESS_CNT_EN
        sat_exp = 64'd255 << 8;
`else
        sat_exp = 64'd0;
`endif
        push("pcnt_key1_sat", SEL_PCNT, cyc, 64'hFF00, sat_exp);
        idle(4);

        // reset in the middle of a debounce
        key[1] = 1'b0;
        idle(3);
        do_reset(2);
        idle(20);

        @(negedge clk);
        #1;
        if (sb_due.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_due.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/board_io_tester.md
Name: board_io_tester

Overview:
Parametrised board bring-up block. It debounces N active-low keys and drives N LEDs with blink patterns that show key state and an external status flag. It also drives an external IO bank with a selectable test pattern: alternating, walking-one or all-high. Instantiated in the board-test top level; it replaces ad-hoc counter/LED/IO assigns.

Parameters:
N_KEYS, 4, number of keys and LEDs (1..16)
N_IO, 34, external IO bank width (2..64)
DIV_W, 25, free-running divider width; slow blink = cnt[DIV_W-1], mid blink = cnt[DIV_W-2]
FAST_BIT, 20, divider bit used for fast blink (< DIV_W-2)
STEP_BIT, 22, walking-one step period = 2^(STEP_BIT+1) cycles (< DIV_W)
DB_CYCLES, 1000000, consecutive stable cycles required to accept a key change (>= 2)
N_STATUS_LEDS, 2, LEDs [N_STATUS_LEDS-1:0] show i_status_ok
MODE_KEY, 3, key index whose press advances IO mode

Ports:
i_sys_clk  in  1  single system clock
i_rst  in  1  synchronous reset, active-high
i_key  in  N_KEYS  raw keys, active-low, asynchronous
i_status_ok  in  1  external status flag (e.g. TF init done), synchronous
o_led  out  N_KEYS  LED drive, registered
o_io  out  N_IO  external IO test pattern, registered
o_key_down  out  N_KEYS  debounced key level, 1 = pressed
o_key_press  out  N_KEYS  one-cycle pulse per accepted press
o_io_mode  out  2  current IO mode: 0 ALT, 1 WALK, 2 ALL_HIGH
o_press_cnt  out  8*N_KEYS  per-key press counters, key k at [8k+7:8k]

Behaviour:
- Reset (i_rst high at clock edge): cnt=0, sync FFs=1, db state=released, debounce counters=0, o_led=0, o_io=0, o_key_down=0, o_key_press=0, mode=ALT, walk pos=0, press counters=0. Reset mid-debounce discards progress.
- Divider: cnt increments every cycle and wraps modulo 2^DIV_W.
- Key path: 2-FF synchroniser per key. A per-key counter increments while the synced sample differs from db state. It clears whenever they match.
  - When counter == DB_CYCLES-1 and the sample still differs: db <= sample, counter <= 0. A change therefore needs DB_CYCLES consecutive differing samples.
  - Total latency from raw edge to o_key_down = 2 + DB_CYCLES cycles.
  - A glitch shorter than DB_CYCLES is ignored.
- o_key_press[k] is high for exactly the cycle in which o_key_down[k] first reads 1. A release generates no pulse.
- LED (registered, 1 cycle after inputs), per key k:
  - pressed: cnt[FAST_BIT].
  - else if k < N_STATUS_LEDS: i_status_ok ? cnt[DIV_W-1] : cnt[DIV_W-2].
  - else: cnt[DIV_W-1].
- Mode FSM ALT -> WALK -> ALL_HIGH -> ALT, advanced only on o_key_press[MODE_KEY]. Each transition sets walk pos=0. Unused encoding 3 recovers to ALT on the next cycle.
- Step tick: high when cnt[STEP_BIT:0] is all ones. In WALK, pos advances on each tick and wraps N_IO-1 -> 0. If a mode-change press coincides with a tick, the mode change wins and pos=0.
- IO (registered):
  - ALT: o_io[i] = cnt[DIV_W-1] for even i, its inverse for odd i.
  - WALK: o_io[i] = (i == pos).
  - ALL_HIGH: all ones.
  - The first cycle after reset outputs 0.

Optional Feature:
BOARD_IO_PRESS_CNT_EN: when defined, each key has an 8-bit counter incremented on o_key_press. It saturates at 255 and is cleared only by reset; o_press_cnt shows the counters. When undefined, no counter logic exists and o_press_cnt is tied to 0.

Decomposition:
- Package board_io_pkg: io_mode_t enum (IO_ALT=0, IO_WALK=1, IO_ALL_HIGH=2), IO_MODE_W=2, PRESS_CNT_W=8.
- Sub-module key_debounce: one key; handles sync, debounce and press pulse; parameter DB_CYCLES. Instantiated N_KEYS times in a generate loop.

Test Plan:
All scenarios use DIV_W=8, FAST_BIT=2, STEP_BIT=3, DB_CYCLES=4, N_IO=6.
- Reset then idle 256 cycles -> o_led[3] follows cnt[7] one cycle late; o_io alternates 101010/010101 with cnt[7]; o_io_mode=0.
- Hold key0 low for 3 cycles then release -> o_key_down stays 0, no press pulse.
- Hold key2 low -> o_key_down[2]=1 exactly 6 cycles after the edge; one-cycle o_key_press[2]; o_led[2] toggles every 4 cycles.
- i_status_ok=0 vs 1 with keys idle -> o_led[1:0] follow cnt[6] vs cnt[7].
- Press key3 once -> mode=1, o_io=000001, then 000010 after next tick, wrapping from 100000 to 000001. Press again -> 111111. Press a third time -> ALT.
- With BOARD_IO_PRESS_CNT_EN, 300 presses on key1 -> o_press_cnt[15:8]=255; without the macro -> 0. Assert reset mid-press -> all counters 0, o_key_down=0.
